// File: rtl/text_attr_pixel_generator.sv
// text_attr_pixel_generator: walks the text screen row by row and
// streams one attributed character-width pixel slice per handshake.
module text_attr_pixel_generator #(
  parameter int TEXT_WIDTH   = 80,
  parameter int TEXT_HEIGHT  = 30,
  parameter int CHAR_WIDTH   = 8,
  parameter int CHAR_HEIGHT  = 16,
  parameter int BLINK_FRAMES = 32,
  localparam int TEXT_LEN = TEXT_WIDTH * TEXT_HEIGHT,
  localparam int TEXT_SZ  = $clog2(TEXT_LEN),
  localparam int COL_SZ   = $clog2(TEXT_WIDTH),
  localparam int ROW_SZ   = $clog2(TEXT_HEIGHT),
  localparam int FONT_AW  = 8 + $clog2(CHAR_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ROW_SZ-1:0]     scroll_row,
  input  logic                  cursor_en,
  input  logic [COL_SZ-1:0]     cursor_col,
  input  logic [ROW_SZ-1:0]     cursor_row,
  output logic [TEXT_SZ-1:0]    text_rd_addr,
  input  logic [15:0]           text_rd_data,
  output logic [FONT_AW-1:0]    font_rd_addr,
  input  logic [CHAR_WIDTH-1:0] font_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHAR_WIDTH-1:0] out_pixels,
  output logic [3:0]            out_fg,
  output logic [2:0]            out_bg,
  output logic [7:0]            out_char,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy
);

  localparam int PR_SZ = $clog2(CHAR_HEIGHT);
  localparam int BL_SZ = $clog2(BLINK_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TXT_WAIT,
    ST_TXT_CAP,
    ST_FNT_WAIT,
    ST_FNT_CAP,
    ST_OUT
  } state_t;

  state_t state;

  logic [COL_SZ-1:0]  col;
  logic [PR_SZ-1:0]   pix_row;
  logic [ROW_SZ-1:0]  text_row;
  logic [TEXT_SZ-1:0] row_base;
  logic [BL_SZ:0]     frame_cnt;
  logic [7:0]         char_q;
  logic [7:0]         attr_q;

  logic [ROW_SZ-1:0]  scroll_eff;
  logic [TEXT_SZ-1:0] base_init;
  logic [31:0]        base_sum;
  logic [TEXT_SZ-1:0] base_nxt;
  logic               last_col;
  logic               last_pr;
  logic               last_row;
  logic               blink_phase;
  logic               cursor_hit;

  // Start base, wrapped next-row base and beat position flags
  always_comb begin
    scroll_eff = scroll_row;
    if (32'(scroll_row) >= TEXT_HEIGHT)
      scroll_eff = '0;
    base_init = TEXT_SZ'(32'(scroll_eff) * TEXT_WIDTH);
    base_sum  = 32'(row_base) + TEXT_WIDTH;
    base_nxt  = TEXT_SZ'(base_sum);
    if (base_sum == TEXT_LEN)
      base_nxt = '0;
    last_col    = (col == COL_SZ'(TEXT_WIDTH - 1));
    last_pr     = (pix_row == PR_SZ'(CHAR_HEIGHT - 1));
    last_row    = (text_row == ROW_SZ'(TEXT_HEIGHT - 1));
    blink_phase = frame_cnt[BL_SZ];
    cursor_hit  = cursor_en
                && (col == cursor_col)
                && (text_row == cursor_row)
                && (pix_row >= PR_SZ'(CHAR_HEIGHT - 2))
                && blink_phase;
  end

  assign busy = (state != ST_IDLE);

  // Fetch / output sequencer; start restarts from any state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      col          <= '0;
      pix_row      <= '0;
      text_row     <= '0;
      row_base     <= '0;
      frame_cnt    <= '0;
      char_q       <= '0;
      attr_q       <= '0;
      text_rd_addr <= '0;
      font_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_pixels   <= '0;
      out_fg       <= '0;
      out_bg       <= '0;
      out_char     <= '0;
      out_eol      <= 1'b0;
      out_eof      <= 1'b0;
    end else if (start) begin
      state        <= ST_TXT_WAIT;
      col          <= '0;
      pix_row      <= '0;
      text_row     <= '0;
      row_base     <= base_init;
      text_rd_addr <= base_init;
      frame_cnt    <= frame_cnt + 1'b1;
      out_valid    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_TXT_WAIT: state <= ST_TXT_CAP;
        ST_TXT_CAP: begin
          char_q       <= text_rd_data[7:0];
          attr_q       <= text_rd_data[15:8];
          font_rd_addr <= {text_rd_data[7:0], pix_row};
          state        <= ST_FNT_WAIT;
        end
        ST_FNT_WAIT: state <= ST_FNT_CAP;
        ST_FNT_CAP: begin
          if (attr_q[7] && !blink_phase)
            out_pixels <= '0;
          else if (cursor_hit)
            out_pixels <= '1;
          else
            out_pixels <= font_rd_data;
          out_fg    <= attr_q[3:0];
          out_bg    <= attr_q[6:4];
          out_char  <= char_q;
          out_eol   <= last_col;
          out_eof   <= last_col && last_pr && last_row;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_eof) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_TXT_WAIT;
              if (!last_col) begin
                col          <= col + 1'b1;
                text_rd_addr <= text_rd_addr + 1'b1;
              end else begin
                col <= '0;
                if (!last_pr) begin
                  pix_row      <= pix_row + 1'b1;
                  text_rd_addr <= row_base;
                end else begin
                  pix_row      <= '0;
                  text_row     <= text_row + 1'b1;
                  row_base     <= base_nxt;
                  text_rd_addr <= base_nxt;
                end
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_attr_pixel_generator.sv
// tb_text_attr_pixel_generator: scoreboard bench on a 4x3 screen
// with 4-row glyphs, model text RAM and font ROM.
module tb_text_attr_pixel_generator;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int CW = 8;
  localparam int CH = 4;
  localparam int BF = 2;
  localparam int TS = 4;
  localparam int CS = 2;
  localparam int RS = 2;
  localparam int FA = 10;
  localparam int NB = TW * TH * CH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [RS-1:0] scroll_row = '0;
  logic          cursor_en = 1'b0;
  logic [CS-1:0] cursor_col = '0;
  logic [RS-1:0] cursor_row = '0;
  logic [TS-1:0] text_rd_addr;
  logic [15:0]   text_rd_data = '0;
  logic [FA-1:0] font_rd_addr;
  logic [CW-1:0] font_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_pixels;
  logic [3:0]    out_fg;
  logic [2:0]    out_bg;
  logic [7:0]    out_char;
  logic          out_eol;
  logic          out_eof;
  logic          busy;

  text_attr_pixel_generator #(
    .TEXT_WIDTH(TW), .TEXT_HEIGHT(TH), .CHAR_WIDTH(CW),
    .CHAR_HEIGHT(CH), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .scroll_row(scroll_row), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .text_rd_addr(text_rd_addr), .text_rd_data(text_rd_data),
    .font_rd_addr(font_rd_addr), .font_rd_data(font_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixels(out_pixels), .out_fg(out_fg), .out_bg(out_bg),
    .out_char(out_char), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TS-1:0] addr;
    logic [FA-1:0] faddr;
    logic [7:0]    pix;
    logic [3:0]    fg;
    logic [2:0]    bg;
    logic [7:0]    ch;
    logic          eol;
    logic          eof;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] ram [16];
  logic [1:0]  fcnt = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          beat_no = 0;
  int          last_hs = 0;
  bit          have_prev = 0;
  bit          spacing = 0;
  bit          rnd_mode = 0;
  bit          stall_prev = 0;
  logic [39:0] snap = '0;
  logic [39:0] snap_now;

  function automatic logic [7:0] font_fn(input logic [FA-1:0] a);
    return {a[5:0], 2'b01} ^ {a[9:6], 4'h0};
  endfunction

  always @(posedge clk) text_rd_data <= ram[text_rd_addr];
  always @(posedge clk) font_rd_data <= font_fn(font_rd_addr);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int scroll);
    int se, tr, pr, c, a, fa;
    logic [15:0] d;
    logic ph;
    beat_t b;
    se = (scroll >= TH) ? 0 : scroll;
    ph = fcnt[1];
    for (int i = 0; i < NB; i++) begin
      tr = i / (TW * CH);
      pr = (i / TW) % CH;
      c  = i % TW;
      a  = ((se + tr) % TH) * TW + c;
      d  = ram[a];
      fa = int'(d[7:0]) * CH + pr;
      b.addr  = TS'(a);
      b.faddr = FA'(fa);
      if (d[15] && !ph)
        b.pix = 8'h00;
      else if (cursor_en && c == int'(cursor_col)
               && tr == int'(cursor_row) && pr >= CH - 2 && ph)
        b.pix = 8'hFF;
      else
        b.pix = font_fn(FA'(fa));
      b.fg  = d[11:8];
      b.bg  = d[14:12];
      b.ch  = d[7:0];
      b.eol = (c == TW - 1);
      b.eof = (i == NB - 1);
      sb.push_back(b);
    end
  endtask

  assign snap_now = {out_valid, out_pixels, out_fg, out_bg, out_char,
                     out_eol, out_eof, text_rd_addr, font_rd_addr};

  // Monitor: pop/compare on handshake, hold check while stalled
  always @(negedge clk) begin
    beat_t e;
    if (reset_n) begin
      if (start) begin
        have_prev = 0;
        beat_no   = 0;
      end
      if (stall_prev)
        chk("stall_stable", snap_now, snap);
      if (out_valid && out_ready && !start) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("b%0d_addr", beat_no), text_rd_addr, e.addr);
          chk($sformatf("b%0d_faddr", beat_no), font_rd_addr, e.faddr);
          chk($sformatf("b%0d_pix", beat_no), out_pixels, e.pix);
          chk($sformatf("b%0d_attr", beat_no),
              {out_fg, out_bg, out_char}, {e.fg, e.bg, e.ch});
          chk($sformatf("b%0d_eol", beat_no), out_eol, e.eol);
          chk($sformatf("b%0d_eof", beat_no), out_eof, e.eof);
          if (spacing && have_prev)
            chk("interval", cyc - last_hs, 5);
          have_prev = 1;
          last_hs   = cyc;
          beat_no++;
        end
      end
      stall_prev = out_valid && !out_ready && !start;
      snap       = snap_now;
    end else begin
      stall_prev = 0;
    end
  end

  // Random consumer stalls of up to 20 cycles
  initial begin
    int hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'b1;
          hold = $urandom_range(0, 20);
        end
      end
    end
  end

  task automatic do_start(input int scroll);
    int se;
    se = (scroll >= TH) ? 0 : scroll;
    @(posedge clk);
    #1;
    scroll_row = RS'(scroll);
    start = 1'b1;
    fcnt++;
    sb.delete();
    push_frame(scroll);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_addr", text_rd_addr, se * TW);
    chk("start_valid", out_valid, 0);
    chk("start_busy", busy, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("lat_e3_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_e4_valid", out_valid, 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("frame_beats", beat_no, NB);
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  initial begin
    int n, nv;
    for (int i = 0; i < 16; i++)
      ram[i] = {8'(i * 19 + 33) & 8'h7F, 8'(i * 7 + 3)};
    ram[5] = {8'h8F, 8'h41};
    ram[6] = {8'h1E, 8'h30};
    ram[9] = {8'h95, 8'h22};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_taddr", text_rd_addr, 0);
    chk("rst_faddr", font_rd_addr, 0);
    chk("rst_pix", out_pixels, 0);
    chk("rst_attr", {out_fg, out_bg, out_char, out_eol, out_eof}, 0);
    reset_n = 1'b1;

    out_ready = 1'b1;
    spacing = 1;
    do_start(0);
    wait_done(400);
    do_start(2);
    wait_done(400);
    do_start(3);
    wait_done(400);

    spacing = 0;
    rnd_mode = 1;
    do_start(1);
    wait_done(5000);
    rnd_mode = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    spacing = 1;
    cursor_en = 1'b1;
    cursor_col = 2'd2;
    cursor_row = 2'd1;
    do_start(0);
    wait_done(400);
    do_start(0);
    wait_done(400);
    do_start(1);
    wait_done(400);

    do_start(0);
    n = 0;
    while (!(beat_no == 6 && out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach", {beat_no[7:0], out_valid}, {8'd6, 1'b1});
    scroll_row = '0;
    start = 1'b1;
    fcnt++;
    sb.delete();
    push_frame(0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mid_valid_drop", out_valid, 0);
    chk("mid_addr", text_rd_addr, 0);
    wait_done(400);

    do_start(2);
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_taddr", text_rd_addr, 0);
    chk("arst_faddr", font_rd_addr, 0);
    chk("arst_pix", out_pixels, 0);
    sb.delete();
    fcnt = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy)
        nv++;
    end
    chk("arst_quiet", nv, 0);
    do_start(0);
    wait_done(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
